// File: rtl/gate_pkg.sv
// Shared opcode definitions and result-FSM encoding for the gate operation arbiter.
package gate_pkg;

  // Opcode field width carried by every requester.
  localparam int OPW = 3;

  // Gate opcodes; OP_RSVD produces y=0 and flags an error.
  typedef enum logic [OPW-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_RSVD = 3'd7
  } gate_op_e;

  // Result register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } res_state_e;

endpackage

// File: rtl/gate_unit.sv
// Combinational single-bit gate evaluator shared by all requesters.
module gate_unit
  import gate_pkg::*;
(
  input  logic           a,
  input  logic           b,
  input  logic [OPW-1:0] op,
  output logic           y,
  output logic           err
);

  // Evaluate the selected gate; the reserved opcode yields 0 with err set.
  always_comb begin
    y   = 1'b0;
    err = 1'b0;
    case (gate_op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_RSVD: begin
        y   = 1'b0;
        err = 1'b1;
      end
      default: begin
        y   = 1'b0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter feeding a shared gate unit, with a one-entry result
// register (EMPTY/FULL) and a wrapping count of accepted operations.
module gate_op_arbiter
  import gate_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ-1:0]     req_a,
  input  logic [NREQ-1:0]     req_b,
  input  logic [OPW*NREQ-1:0] req_op,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_y,
  output logic [IDW-1:0]      res_id,
  output logic                res_err,
  output logic [7:0]          op_count
);

  res_state_e       state_r;
  res_state_e       state_nxt_s;
  logic [2:0]       ptr_r;
  logic             res_y_r;
  logic [IDW-1:0]   res_id_r;
  logic             res_err_r;
  logic [7:0]       op_count_r;

  logic             can_accept_s;
  logic             found_s;
  logic [IDW-1:0]   win_s;
  logic [IDW-1:0]   cand_s;
  logic             xfer_s;
  logic             sel_a_s;
  logic             sel_b_s;
  logic [OPW-1:0]   sel_op_s;
  logic             gate_y_s;
  logic             gate_err_s;
  logic [OPW-1:0]   op_arr_s [NREQ];

  // Split the flat opcode bus into one field per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_op_split
    assign op_arr_s[g] = req_op[g*OPW +: OPW];
  end

  // A new result can be taken when the register is empty or being drained.
  assign can_accept_s = (state_r == ST_EMPTY) | res_ready;

  // Round-robin search: first valid requester starting at ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    win_s   = {IDW{1'b0}};
    cand_s  = {IDW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      cand_s = IDW'((int'(ptr_r) + k) % NREQ);
      if (!found_s && req_valid[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant only while out of reset; a grant is always a transfer.
  assign xfer_s = rst_n & can_accept_s & found_s;

  // One-hot ready towards the winner, all zero otherwise.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    if (xfer_s) begin
      req_ready[win_s] = 1'b1;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Route only the winner's operands to the shared gate.
  always_comb begin
    sel_a_s  = req_a[win_s];
    sel_b_s  = req_b[win_s];
    sel_op_s = op_arr_s[win_s];
  end

  gate_unit u_gate_unit (
    .a   (sel_a_s),
    .b   (sel_b_s),
    .op  (sel_op_s),
    .y   (gate_y_s),
    .err (gate_err_s)
  );

  // Result FSM next state: fill on transfer, drain on res_ready without refill.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_EMPTY: begin
        if (xfer_s) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (res_ready && !xfer_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: state_nxt_s = ST_EMPTY;
    endcase
  end

  // Result FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture result, advance pointer past the winner and count the operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_y_r    <= 1'b0;
      res_id_r   <= {IDW{1'b0}};
      res_err_r  <= 1'b0;
      op_count_r <= 8'd0;
      ptr_r      <= 3'd0;
    end else if (xfer_s) begin
      res_y_r    <= gate_y_s;
      res_id_r   <= win_s;
      res_err_r  <= gate_err_s;
      op_count_r <= op_count_r + 8'd1;
      ptr_r      <= 3'((int'(win_s) + 1) % NREQ);
    end
  end

  assign res_valid = (state_r == ST_FULL);
  assign res_y     = res_y_r;
  assign res_id    = res_id_r;
  assign res_err   = res_err_r;
  assign op_count  = op_count_r;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// random traffic compared against a queue-free behavioural model.
module tb_gate_op_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [3:0]  req_a;
  logic [3:0]  req_b;
  logic [11:0] req_op;
  logic        res_valid;
  logic        res_ready;
  logic        res_y;
  logic [1:0]  res_id;
  logic        res_err;
  logic [7:0]  op_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_ptr;
  bit m_full;
  bit m_y;
  int m_id;
  bit m_err;
  int m_cnt;

  gate_op_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_y     (res_y),
    .res_id    (res_id),
    .res_err   (res_err),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  valid;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [11:0] op;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic        exp_y;
    logic [1:0]  exp_id;
    logic        exp_err;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit gate_ref(input bit a, input bit b, input int op);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return !(a & b);
      3: return !(a | b);
      4: return a ^ b;
      5: return !(a ^ b);
      6: return !a;
      default: return 1'b0;
    endcase
  endfunction

  // Caller sits just after a rising edge; reset is asserted immediately.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_y", 32'(res_y), 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ptr = 0; m_full = 0; m_y = 0; m_id = 0; m_err = 0; m_cnt = 0;
  endtask

  // One cycle against the model, using the inputs already driven.
  task automatic step();
    int win;
    bit can;
    logic [3:0] er;
    int op;
    can = !m_full || res_ready;
    win = -1;
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (m_ptr + k) % 4;
      if (win < 0 && req_valid[j]) win = j;
    end
    er = (can && win >= 0) ? 4'(1 << win) : 4'b0000;
    #1;
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    #1;
    if (er != 4'b0000) begin
      op     = int'(req_op[3*win +: 3]);
      m_full = 1;
      m_y    = gate_ref(req_a[win], req_b[win], op);
      m_id   = win;
      m_err  = (op == 7);
      m_cnt  = (m_cnt + 1) % 256;
      m_ptr  = (win + 1) % 4;
    end else if (res_ready) begin
      m_full = 0;
    end
    chk("res_valid", 32'(res_valid), 32'(m_full));
    chk("op_count", 32'(op_count), 32'(m_cnt));
    if (m_full) begin
      chk("res_y", 32'(res_y), 32'(m_y));
      chk("res_id", 32'(res_id), 32'(m_id));
      chk("res_err", 32'(res_err), 32'(m_err));
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 4'b0; req_a = 4'b0; req_b = 4'b0;
    req_op = 12'h000; res_ready = 1'b0;
    @(posedge clk);
    #1;

    // Directed table
    vt[0]  = '{1'b1, 4'b0100, 4'b0100, 4'b0000, 12'h100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 8'd1};
    vt[1]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 12'h249, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 8'd1};
    vt[2]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 12'h249, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0, 8'd2};
    vt[3]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 12'h249, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 8'd3};
    vt[4]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 12'h249, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 1'b0, 8'd4};
    vt[5]  = '{1'b0, 4'b1111, 4'b1111, 4'b0000, 12'h249, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 8'd5};
    vt[6]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 12'h000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 8'd5};
    vt[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 12'h000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 8'd5};
    vt[8]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 12'h000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 8'd5};
    vt[9]  = '{1'b0, 4'b1111, 4'b0000, 4'b0000, 12'h000, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b0, 8'd6};
    vt[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 12'h000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 8'd6};
    vt[11] = '{1'b0, 4'b1000, 4'b1000, 4'b1000, 12'hE00, 1'b1, 4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 8'd7};

    for (int i = 0; i < 12; i++) begin
      if (vt[i].rst) do_reset();
      req_valid = vt[i].valid; req_a = vt[i].a; req_b = vt[i].b;
      req_op = vt[i].op; res_ready = vt[i].rr;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(vt[i].exp_ready));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), 32'(res_valid), 32'(vt[i].exp_valid));
      chk($sformatf("tbl%0d_cnt", i), 32'(op_count), 32'(vt[i].exp_cnt));
      if (vt[i].exp_valid) begin
        chk($sformatf("tbl%0d_y", i), 32'(res_y), 32'(vt[i].exp_y));
        chk($sformatf("tbl%0d_id", i), 32'(res_id), 32'(vt[i].exp_id));
        chk($sformatf("tbl%0d_err", i), 32'(res_err), 32'(vt[i].exp_err));
      end
    end

    // Opcode sweep on requester 1; other lanes carry junk but are not valid
    do_reset();
    res_ready = 1'b1;
    for (int op = 0; op < 8; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        req_valid = 4'b0010;
        req_a = 4'($urandom); req_b = 4'($urandom); req_op = 12'($urandom);
        req_a[1] = ab[1]; req_b[1] = ab[0]; req_op[5:3] = 3'(op);
        step();
      end
    end

    // Asynchronous reset while FULL with ptr=3, then search restarts at 0
    do_reset();
    req_valid = 4'b0111; req_a = 4'b1111; req_b = 4'b1111; req_op = 12'h000; res_ready = 1'b1;
    step(); step(); step();
    res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(res_valid), 32'd0);
    chk("async_rst_cnt", 32'(op_count), 32'd0);
    @(posedge clk);
    #1;
    do_reset();
    req_valid = 4'b1111; res_ready = 1'b1;
    #1;
    chk("post_rst_grant0", 32'(req_ready), 32'b0001);
    #1;
    step();

    // Random traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a = 4'($urandom); req_b = 4'($urandom); req_op = 12'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    // Counter wrap after 256 operations from reset
    do_reset();
    req_valid = 4'b1111; res_ready = 1'b1; req_op = 12'hFFF;
    for (int i = 0; i < 256; i++) begin
      req_a = 4'($urandom); req_b = 4'($urandom);
      step();
    end
    chk("op_count_wrap", 32'(op_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
